// File: rtl/kick_sequencer_if.sv
// Signal bundle between the kick command/monitor side and the kick sequencer.
// The slave modport is the sequencer view.
interface kick_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_abort;
   logic       done_in;
   logic       trigger_in;
   logic       kick;
   logic       busy;
   logic       kick_done;
   logic       fault;
   logic [1:0] fault_code;
   logic       fault_clr;
   logic [7:0] kick_count;

   modport master (
      output cmd_valid, cmd_abort, done_in, trigger_in, fault_clr,
      input  cmd_ready, kick, busy, kick_done, fault, fault_code, kick_count
   );

   modport slave (
      input  cmd_valid, cmd_abort, done_in, trigger_in, fault_clr,
      output cmd_ready, kick, busy, kick_done, fault, fault_code, kick_count
   );
endinterface

// File: rtl/kick_sequencer.sv
// Kick initiator: waits for a stable charge, fires a one-cycle kick, confirms the
// discharge window, enforces cooldown and latches charger/driver timeouts as faults.
module kick_sequencer #(
   parameter int STABLE_CYCLES     = 4,
   parameter int CHARGE_TIMEOUT    = 50_000_000,
   parameter int CONFIRM_TIMEOUT   = 8,
   parameter int DISCHARGE_TIMEOUT = 2_097_152,
   parameter int COOLDOWN_CYCLES   = 1_000_000,
   parameter int TW                = 26
) (
   input logic              clk,
   input logic              reset,
   kick_sequencer_if.slave  bus
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);

   localparam logic [TW-1:0] CHARGE_LAST    = TW'(CHARGE_TIMEOUT - 1);
   localparam logic [TW-1:0] CONFIRM_LAST   = TW'(CONFIRM_TIMEOUT - 1);
   localparam logic [TW-1:0] DISCHARGE_LAST = TW'(DISCHARGE_TIMEOUT - 1);
   localparam logic [TW-1:0] COOLDOWN_LAST  = TW'(COOLDOWN_CYCLES - 1);
   localparam logic [SW-1:0] STABLE_FULL    = SW'(STABLE_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CHARGE,
      FIRE,
      CONFIRM,
      DISCHARGE,
      COOLDOWN,
      FAULT
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [1:0]    next_code;
   logic [TW-1:0] timer;
   logic [SW-1:0] stable;
   logic          kick_r;
   logic          kick_done_r;
   logic [1:0]    fault_code_r;
   logic [7:0]    kick_count_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Abort beats fire beats charge timeout; a trigger edge on the last
   // confirm/discharge cycle beats the timeout.
   always_comb begin
      next_state = state;
      next_code  = fault_code_r;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) next_state = WAIT_CHARGE;
         end
         WAIT_CHARGE: begin
            if (bus.cmd_abort) begin
               next_state = IDLE;
            end else if (stable == STABLE_FULL) begin
               next_state = FIRE;
            end else if (timer == CHARGE_LAST) begin
               next_state = FAULT;
               next_code  = 2'd1;
            end
         end
         FIRE: begin
            next_state = CONFIRM;
         end
         CONFIRM: begin
            if (bus.trigger_in) begin
               next_state = DISCHARGE;
            end else if (timer == CONFIRM_LAST) begin
               next_state = FAULT;
               next_code  = 2'd2;
            end
         end
         DISCHARGE: begin
            if (!bus.trigger_in) begin
               next_state = COOLDOWN;
            end else if (timer == DISCHARGE_LAST) begin
               next_state = FAULT;
               next_code  = 2'd3;
            end
         end
         COOLDOWN: begin
            if (timer == COOLDOWN_LAST) next_state = IDLE;
         end
         FAULT: begin
            if (bus.fault_clr) begin
               next_state = IDLE;
               next_code  = 2'd0;
            end
         end
         default: begin
            next_state = IDLE;
            next_code  = 2'd0;
         end
      endcase
   end

   // The timer restarts on every state change and idles at zero where no limit applies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer        <= '0;
         stable       <= '0;
         kick_r       <= 1'b0;
         kick_done_r  <= 1'b0;
         fault_code_r <= 2'd0;
         kick_count_r <= 8'd0;
      end else begin
         if (next_state != state || state == IDLE || state == FAULT) begin
            timer <= '0;
         end else begin
            timer <= timer + TW'(1);
         end

         if (state != WAIT_CHARGE || !bus.done_in) begin
            stable <= '0;
         end else if (stable != STABLE_FULL) begin
            stable <= stable + SW'(1);
         end

         kick_r       <= (next_state == FIRE);
         kick_done_r  <= (state == COOLDOWN) && (next_state == IDLE);
         fault_code_r <= next_code;
         if ((state == COOLDOWN) && (next_state == IDLE)) begin
            kick_count_r <= kick_count_r + 8'd1;
         end
      end
   end

   assign bus.cmd_ready  = (state == IDLE);
   assign bus.fault      = (state == FAULT);
   assign bus.busy       = (state != IDLE) && (state != FAULT);
   assign bus.kick       = kick_r;
   assign bus.kick_done  = kick_done_r;
   assign bus.fault_code = fault_code_r;
   assign bus.kick_count = kick_count_r;

endmodule

// File: tb/tb_kick_sequencer.sv
// Randomized bench for kick_sequencer: a per-edge expected-output schedule is built
// from the timing rules, then applied to the DUT and compared edge by edge.
module tb_kick_sequencer;

   localparam int STABLE     = 2;
   localparam int CHARGE_TO  = 16;
   localparam int CONFIRM_TO = 4;
   localparam int DIS_TO     = 32;
   localparam int COOL       = 8;

   localparam int E_IDLE  = 0;
   localparam int E_BUSY  = 1;
   localparam int E_KICK  = 2;
   localparam int E_FAULT = 3;
   localparam int E_DONE  = 4;

   localparam int M_PLAN       = 0;
   localparam int M_NORMAL     = 1;
   localparam int M_GLITCH     = 2;
   localparam int M_RANDDONE   = 3;
   localparam int M_TIMEOUT    = 4;
   localparam int M_ABORT      = 5;
   localparam int M_ABORT_FIRE = 6;
   localparam int M_NOTRIG     = 7;
   localparam int M_LASTCONF   = 8;
   localparam int M_STUCK      = 9;
   localparam int M_LASTDIS    = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;

   kick_sequencer_if bus();

   kick_sequencer #(
      .STABLE_CYCLES     (STABLE),
      .CHARGE_TIMEOUT    (CHARGE_TO),
      .CONFIRM_TIMEOUT   (CONFIRM_TO),
      .DISCHARGE_TIMEOUT (DIS_TO),
      .COOLDOWN_CYCLES   (COOL),
      .TW                (26)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       cv, ab, dn, tr, fc;
      logic       kick, kd, flt, busy;
      logic [1:0] code;
      logic [7:0] cnt;
   } step_t;

   step_t      sched[$];
   logic [7:0] m_cnt;
   int         vectors;
   int         miscompares;
   int         n_ok;
   int         cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic cv, ab, dn, tr, fc, input int cls, input logic [1:0] code);
      step_t s;
      s.cv   = cv;
      s.ab   = ab;
      s.dn   = dn;
      s.tr   = tr;
      s.fc   = fc;
      s.kick = (cls == E_KICK);
      s.kd   = (cls == E_DONE);
      s.flt  = (cls == E_FAULT);
      s.busy = (cls == E_BUSY) || (cls == E_KICK);
      s.code = (cls == E_FAULT) ? code : 2'd0;
      s.cnt  = m_cnt;
      sched.push_back(s);
   endtask

   // Entry edge already scheduled by the caller; hold a few edges, then clear.
   task automatic fault_seq(input logic [1:0] code);
      int hold;
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) push(rb(), rb(), rb(), rb(), 1'b0, E_FAULT, code);
      push(rb(), rb(), rb(), rb(), 1'b1, E_IDLE, 2'd0);
   endtask

   task automatic txn(input int mode);
      logic d[CHARGE_TO];
      logic dn, tr, ok, fired;
      int   abort_j, r, len;
      abort_j = -1;
      r   = $urandom_range(0, CONFIRM_TO - 1);
      len = $urandom_range(1, DIS_TO - 1);
      case (mode)
         M_PLAN:       begin r = 0; len = 10; end
         M_GLITCH:     begin r = 0; len = 10; end
         M_ABORT:      abort_j = $urandom_range(0, CHARGE_TO - 1);
         M_ABORT_FIRE: abort_j = STABLE;
         M_NOTRIG:     r = CONFIRM_TO;
         M_LASTCONF:   r = CONFIRM_TO - 1;
         M_STUCK:      len = DIS_TO + $urandom_range(0, 3);
         M_LASTDIS:    len = DIS_TO - 1;
         default:      ;
      endcase

      push(1'b1, rb(), rb(), rb(), rb(), E_BUSY, 2'd0);

      // Charge: fire once the previous STABLE samples were all high.
      fired = 1'b0;
      for (int j = 0; j < CHARGE_TO && !fired; j++) begin
         case (mode)
            M_TIMEOUT:           dn = 1'b0;
            M_RANDDONE, M_ABORT: dn = ($urandom_range(0, 3) != 0);
            M_GLITCH:            dn = (j < 4) ? ((j % 2) == 0) : 1'b1;
            default:             dn = 1'b1;
         endcase
         ok = (j >= STABLE);
         if (j >= STABLE) begin
            for (int k = 1; k <= STABLE; k++) if (!d[j-k]) ok = 1'b0;
         end
         if (j == abort_j) begin
            push(rb(), 1'b1, dn, rb(), rb(), E_IDLE, 2'd0);
            return;
         end else if (ok) begin
            push(rb(), 1'b0, dn, rb(), rb(), E_KICK, 2'd0);
            fired = 1'b1;
         end else if (j == CHARGE_TO - 1) begin
            push(rb(), 1'b0, dn, rb(), rb(), E_FAULT, 2'd1);
            fault_seq(2'd1);
            return;
         end else begin
            push(rb(), 1'b0, dn, rb(), rb(), E_BUSY, 2'd0);
         end
         d[j] = dn;
      end

      push(rb(), rb(), rb(), rb(), rb(), E_BUSY, 2'd0);

      for (int j = 0; j < CONFIRM_TO; j++) begin
         tr = (j >= r);
         if (tr) begin
            push(rb(), rb(), rb(), 1'b1, rb(), E_BUSY, 2'd0);
            break;
         end else if (j == CONFIRM_TO - 1) begin
            push(rb(), rb(), rb(), 1'b0, rb(), E_FAULT, 2'd2);
            fault_seq(2'd2);
            return;
         end else begin
            push(rb(), rb(), rb(), 1'b0, rb(), E_BUSY, 2'd0);
         end
      end

      for (int j = 0; j < DIS_TO; j++) begin
         tr = (j < len);
         if (!tr) begin
            push(rb(), rb(), rb(), 1'b0, rb(), E_BUSY, 2'd0);
            break;
         end else if (j == DIS_TO - 1) begin
            push(rb(), rb(), rb(), 1'b1, rb(), E_FAULT, 2'd3);
            fault_seq(2'd3);
            return;
         end else begin
            push(rb(), rb(), rb(), 1'b1, rb(), E_BUSY, 2'd0);
         end
      end

      for (int j = 0; j < COOL; j++) begin
         if (j == COOL - 1) begin
            m_cnt = m_cnt + 8'd1;
            n_ok++;
            push(rb(), rb(), rb(), rb(), rb(), E_DONE, 2'd0);
         end else begin
            push(rb(), rb(), rb(), rb(), rb(), E_BUSY, 2'd0);
         end
      end
   endtask

   task automatic gap();
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) push(1'b0, rb(), rb(), rb(), rb(), E_IDLE, 2'd0);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_kick"},       32'(bus.kick),       32'd0);
      check({pfx, "_kick_done"},  32'(bus.kick_done),  32'd0);
      check({pfx, "_fault"},      32'(bus.fault),      32'd0);
      check({pfx, "_busy"},       32'(bus.busy),       32'd0);
      check({pfx, "_fault_code"}, 32'(bus.fault_code), 32'd0);
      check({pfx, "_kick_count"}, 32'(bus.kick_count), 32'd0);
      check({pfx, "_cmd_ready"},  32'(bus.cmd_ready),  32'd1);
   endtask

   initial begin
      int    ntx;
      int    mode;
      step_t s;

      vectors     = 0;
      miscompares = 0;
      n_ok        = 0;
      cyc         = 0;
      m_cnt       = 8'd0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_abort  = 1'b0;
      bus.done_in    = 1'b0;
      bus.trigger_in = 1'b0;
      bus.fault_clr  = 1'b0;

      push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, 2'd0);
      txn(M_PLAN);       gap();
      txn(M_TIMEOUT);    gap();
      txn(M_GLITCH);     gap();
      txn(M_NOTRIG);     gap();
      txn(M_STUCK);      gap();
      txn(M_ABORT);      gap();
      txn(M_ABORT_FIRE); gap();
      txn(M_LASTCONF);   gap();
      txn(M_LASTDIS);    gap();
      ntx = 9;
      while ((n_ok < 260 || ntx < 300) && ntx < 2000) begin
         mode = $urandom_range(0, 15);
         if (mode > M_LASTDIS) mode = M_NORMAL;
         txn(mode);
         gap();
         ntx++;
      end
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 2'd0);

      @(negedge clk);
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < sched.size(); i++) begin
         s = sched[i];
         bus.cmd_valid  = s.cv;
         bus.cmd_abort  = s.ab;
         bus.done_in    = s.dn;
         bus.trigger_in = s.tr;
         bus.fault_clr  = s.fc;
         @(posedge clk);
         @(negedge clk);
         cyc = i;
         check("kick",       32'(bus.kick),       32'(s.kick));
         check("kick_done",  32'(bus.kick_done),  32'(s.kd));
         check("fault",      32'(bus.fault),      32'(s.flt));
         check("busy",       32'(bus.busy),       32'(s.busy));
         check("cmd_ready",  32'(bus.cmd_ready),  32'(!s.busy && !s.flt));
         check("fault_code", 32'(bus.fault_code), 32'(s.code));
         check("kick_count", 32'(bus.kick_count), 32'(s.cnt));
      end

      // Reset landing on the kick cycle.
      bus.cmd_valid  = 1'b1;
      bus.done_in    = 1'b1;
      bus.trigger_in = 1'b0;
      bus.cmd_abort  = 1'b0;
      bus.fault_clr  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cyc = -1;
      check("pre_reset_kick", 32'(bus.kick), 32'd1);
      reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("post_reset_kick", 32'(bus.kick), 32'd0);
         check("post_reset_busy", 32'(bus.busy), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
